truth_table_sweeper: RTL and testbench
======================================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, SHALL set the cycles each input vector is held before z is sampled; legal range 1..15.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 start  input  1  SHALL request a sweep; sampled only in IDLE.
REQ-005 expected  input  8  SHALL be the golden truth table, bit i = expected z for abc = i; latched on start acceptance.
REQ-006 z_in  input  1  SHALL be the output of the combinational unit under test.
REQ-007 a, b, c  output  1 each  SHALL drive the unit under test, registered; a = MSB of vector index, c = LSB.
REQ-008 truth  output  8  SHALL be the captured truth table, bit i = z_in sampled for vector i.
REQ-009 busy  output  1  SHALL be high in SETTLE and SAMPLE.
REQ-010 done  output  1  SHALL be a single-cycle pulse at sweep completion.
REQ-011 pass  output  1  SHALL be high when the last completed sweep had zero mismatches.
REQ-012 mismatch_count  output  4  SHALL be the number of vectors where z_in differed from expected (0..8).

Function
REQ-013 FSM states SHALL be IDLE, SETTLE, SAMPLE, DONE.
REQ-014 IDLE with start=1 at an edge: SHALL set index=0, {a,b,c}=000, latch expected, clear truth, mismatch_count, pass, settle counter; go to SETTLE.
REQ-015 SETTLE SHALL last exactly SETTLE_CYCLES cycles (counter 0..SETTLE_CYCLES-1), then go to SAMPLE.
REQ-016 SAMPLE SHALL last one cycle; at its closing edge truth[index] <= z_in; mismatch_count increments if z_in != expected_latched[index].
REQ-017 At that same edge, if index<7: index, {a,b,c} increment, counter cleared, go to SETTLE; if index=7: go to DONE, {a,b,c} hold 111.
REQ-018 Each vector SHALL be held exactly SETTLE_CYCLES+1 cycles; vectors SHALL appear in order 000..111 with no gaps or repeats.
REQ-019 DONE SHALL last one cycle with done=1 and pass = (mismatch_count==0) registered at DONE entry; then IDLE.
REQ-020 done SHALL rise at edge k+8*(SETTLE_CYCLES+1) where k is the start-accepting edge (24 cycles at default).
REQ-021 start while busy or in DONE SHALL be ignored; no restart, no extra done.
REQ-022 truth, pass, mismatch_count, {a,b,c} SHALL hold their values in IDLE until the next accepted start.
REQ-023 mismatch_count SHALL never wrap; max value 8.

Reset
REQ-024 rst=1 SHALL immediately force IDLE and a=b=c=0, truth=0, busy=0, done=0, pass=0, mismatch_count=0, index=0, counter=0, regardless of state.
REQ-025 Reset mid-sweep SHALL discard partial results; no done pulse SHALL follow; first start after rst release SHALL run a full sweep.

Structure
REQ-026 Shared package truth_sweep_pkg SHALL hold the state enum, VEC_COUNT=8, IDX_W=3, CNT_W=4.
REQ-027 Block SHALL be a single module; no sub-module needed (settle counter is inline).

Verification
REQ-028 z_in = majority(a,b,c), expected=8'hE8, SETTLE_CYCLES=2 -> done at cycle 24 after start, truth=8'hE8, pass=1, mismatch_count=0.
REQ-029 Same model, expected=8'hE9 -> truth=8'hE8, mismatch_count=1, pass=0.
REQ-030 z_in tied 0, expected=8'hFF -> truth=8'h00, mismatch_count=8, pass=0.
REQ-031 Monitor {a,b,c}: 000..111 each held exactly 3 cycles at default, 2 cycles with SETTLE_CYCLES=1 (done at cycle 16).
REQ-032 start pulsed again at cycles 5 and 20 of a sweep -> ignored, exactly one done, results unchanged from REQ-028.
REQ-033 rst asserted while {a,b,c}=100 -> all outputs 0 asynchronously, no done; subsequent start -> REQ-028 results.

Source files
------------

// File: rtl/truth_sweep_pkg.sv
// Shared types and sizing for the truth-table sweeper.
`default_nettype none

package truth_sweep_pkg;

  localparam int VEC_COUNT = 8;
  localparam int IDX_W     = 3;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// Drives all eight abc input vectors into a 3-input combinational unit, captures
// its truth table and compares it against a golden table latched at start.
`default_nettype none

module truth_table_sweeper
  import truth_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       z_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [7:0] truth,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] mismatch_count
);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       exp_q;
  logic [7:0]       truth_q;
  logic [3:0]       mm_q;
  logic             pass_q;
  logic             busy_q;
  logic             done_q;

  logic             miss_d;
  logic [3:0]       mm_d;
  logic             last_vec_d;
  logic             settle_end_d;

  // The vector index doubles as the registered abc drive, so it always matches
  // the vector being sampled.
  always_comb begin
    miss_d       = z_in ^ exp_q[idx_q];
    mm_d         = (mm_q == 4'(VEC_COUNT)) ? mm_q : mm_q + {3'b000, miss_d};
    last_vec_d   = (idx_q == IDX_W'(VEC_COUNT - 1));
    settle_end_d = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      truth_q <= '0;
      mm_q    <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= ST_SETTLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= expected;
            truth_q <= '0;
            mm_q    <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_end_d) begin
            state_q <= ST_SAMPLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_SAMPLE: begin
          truth_q[idx_q] <= z_in;
          mm_q           <= mm_d;
          if (last_vec_d) begin
            // pass reflects the final count, including this last sample.
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (mm_d == 4'd0);
          end else begin
            state_q <= ST_SETTLE;
            idx_q   <= idx_q + 1'b1;
            cnt_q   <= '0;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a              = idx_q[2];
  assign b              = idx_q[1];
  assign c              = idx_q[0];
  assign truth          = truth_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign mismatch_count = mm_q;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: majority / stuck-at-0 units under test, settle timing, start
// filtering and asynchronous reset recovery.
`default_nettype none

module tb_truth_table_sweeper;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] expected;
  logic       z_mode;
  logic       z_in;
  logic       a, b, c;
  logic [7:0] truth;
  logic       busy, done, pass;
  logic [3:0] mismatch_count;

  logic       start2;
  logic [7:0] expected2;
  logic       z_in2;
  logic       a2, b2, c2;
  logic [7:0] truth2;
  logic       busy2, done2, pass2;
  logic [3:0] mismatch_count2;

  int checks;
  int failures;

  assign z_in  = z_mode ? ((a & b) | (a & c) | (b & c)) : 1'b0;
  assign z_in2 = (a2 & b2) | (a2 & c2) | (b2 & c2);

  truth_table_sweeper #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .expected(expected), .z_in(z_in),
    .a(a), .b(b), .c(c), .truth(truth), .busy(busy), .done(done),
    .pass(pass), .mismatch_count(mismatch_count)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .expected(expected2), .z_in(z_in2),
    .a(a2), .b(b2), .c(c2), .truth(truth2), .busy(busy2), .done(done2),
    .pass(pass2), .mismatch_count(mismatch_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one sweep on dut (hold = 3 cycles per vector). Sample j is taken 1ns
  // after edge k+j, where k is the start-accepting edge.
  task automatic sweep1(input logic [7:0] exp, input bit repulse,
                        output int cyc, output int verr, output int ndone);
    @(negedge clk);
    expected = exp;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    expected = ~exp;
    cyc = -1; verr = 0; ndone = 0;
    for (int j = 0; j < 60; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      if (j < 24 && ({a, b, c} !== 3'(j / 3) || busy !== 1'b1)) verr++;
      if (j >= 24 && ({a, b, c} !== 3'b111 || busy !== 1'b0)) verr++;
      if (done === 1'b1) begin
        ndone++;
        if (cyc < 0) cyc = j;
      end
      if (repulse) start = (j == 5 || j == 20 || j == 24);
    end
    start = 1'b0;
  endtask

  task automatic check_sweep(input string name, input int cyc, input int verr,
                             input int ndone, input logic [7:0] t,
                             input logic [3:0] mm, input logic p);
    checks++;
    if (cyc !== 24) begin failures++; $display("FAIL %s_latency: got %0d want 24", name, cyc); end
    checks++;
    if (ndone !== 1) begin failures++; $display("FAIL %s_done_count: got %0d want 1", name, ndone); end
    checks++;
    if (verr !== 0) begin failures++; $display("FAIL %s_vector_seq: got %0d errors want 0", name, verr); end
    checks++;
    if (truth !== t) begin failures++; $display("FAIL %s_truth: got %h want %h", name, truth, t); end
    checks++;
    if (mismatch_count !== mm) begin failures++; $display("FAIL %s_mismatch: got %0d want %0d", name, mismatch_count, mm); end
    checks++;
    if (pass !== p) begin failures++; $display("FAIL %s_pass: got %b want %b", name, pass, p); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    expected = 8'h00; expected2 = 8'h00; z_mode = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a, b, c} !== 3'b000) begin failures++; $display("FAIL reset_abc: got %b want 000", {a, b, c}); end
    checks++;
    if (truth !== 8'h00) begin failures++; $display("FAIL reset_truth: got %h want 00", truth); end
    checks++;
    if ({busy, done, pass} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {busy, done, pass}); end
    checks++;
    if (mismatch_count !== 4'd0) begin failures++; $display("FAIL reset_mismatch: got %0d want 0", mismatch_count); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_majority_pass();
    int cyc, verr, ndone;
    z_mode = 1'b1;
    sweep1(8'hE8, 1'b0, cyc, verr, ndone);
    check_sweep("maj_pass", cyc, verr, ndone, 8'hE8, 4'd0, 1'b1);
  endtask

  task automatic test_single_mismatch();
    int cyc, verr, ndone;
    z_mode = 1'b1;
    sweep1(8'hE9, 1'b0, cyc, verr, ndone);
    check_sweep("maj_e9", cyc, verr, ndone, 8'hE8, 4'd1, 1'b0);
  endtask

  task automatic test_all_mismatch();
    int cyc, verr, ndone;
    z_mode = 1'b0;
    sweep1(8'hFF, 1'b0, cyc, verr, ndone);
    check_sweep("stuck0", cyc, verr, ndone, 8'h00, 4'd8, 1'b0);
    z_mode = 1'b1;
  endtask

  task automatic test_start_ignored();
    int cyc, verr, ndone;
    z_mode = 1'b1;
    sweep1(8'hE8, 1'b1, cyc, verr, ndone);
    check_sweep("restart", cyc, verr, ndone, 8'hE8, 4'd0, 1'b1);
  endtask

  task automatic test_settle1();
    int cyc, verr, ndone;
    @(negedge clk);
    expected2 = 8'hE8;
    start2    = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    cyc = -1; verr = 0; ndone = 0;
    for (int j = 0; j < 30; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      if (j < 16 && {a2, b2, c2} !== 3'(j / 2)) verr++;
      if (j >= 16 && {a2, b2, c2} !== 3'b111) verr++;
      if (done2 === 1'b1) begin
        ndone++;
        if (cyc < 0) cyc = j;
      end
    end
    checks++;
    if (cyc !== 16) begin failures++; $display("FAIL settle1_latency: got %0d want 16", cyc); end
    checks++;
    if (verr !== 0 || ndone !== 1) begin failures++; $display("FAIL settle1_seq: got %0d errors %0d dones want 0 errors 1 done", verr, ndone); end
    checks++;
    if ({truth2, mismatch_count2, pass2} !== {8'hE8, 4'd0, 1'b1}) begin
      failures++;
      $display("FAIL settle1_result: got truth=%h mm=%0d pass=%b want truth=e8 mm=0 pass=1", truth2, mismatch_count2, pass2);
    end
  endtask

  task automatic test_reset_midsweep();
    int cyc, verr, ndone;
    int nd;
    bit found;
    z_mode = 1'b1;
    @(negedge clk);
    expected = 8'hE8;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if ({a, b, c} === 3'b100) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL midrst_reach100: got abc=%b want 100", {a, b, c}); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({a, b, c, busy, done, pass} !== 6'b0 || truth !== 8'h00 || mismatch_count !== 4'd0) begin
      failures++;
      $display("FAIL midrst_async: got abc=%b busy=%b done=%b pass=%b truth=%h mm=%0d want all 0",
               {a, b, c}, busy, done, pass, truth, mismatch_count);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) nd++;
    end
    checks++;
    if (nd !== 0) begin failures++; $display("FAIL midrst_no_done: got %0d active cycles want 0", nd); end
    sweep1(8'hE8, 1'b0, cyc, verr, ndone);
    check_sweep("after_rst", cyc, verr, ndone, 8'hE8, 4'd0, 1'b1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_majority_pass();
    test_single_mismatch();
    test_all_mismatch();
    test_start_ignored();
    test_settle1();
    test_reset_midsweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
